// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU command sequencer and its bench.
//   - Opcode encodings for the 16-bit ALU (0x0-0xA legal, 0xB-0xF illegal).
//   - Default latencies, in clock edges from accept to result capture.
//   - Sequencer state encoding.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_OR   = 4'h1;
    localparam logic [3:0] OP_XOR  = 4'h2;
    localparam logic [3:0] OP_ASHR = 4'h3;
    localparam logic [3:0] OP_SHR  = 4'h4;
    localparam logic [3:0] OP_SHL  = 4'h5;
    localparam logic [3:0] OP_ADD  = 4'h6;
    localparam logic [3:0] OP_SUB  = 4'h7;
    localparam logic [3:0] OP_MUL  = 4'h8;
    localparam logic [3:0] OP_DIV  = 4'h9;
    localparam logic [3:0] OP_REM  = 4'hA;
    localparam logic [3:0] OP_MAX  = 4'hA;

    localparam int LAT_REG_DEF  = 2;
    localparam int LAT_COMB_DEF = 1;
    localparam int LAT_MUL_DEF  = 18;
    localparam int LAT_DIV_DEF  = 18;
    localparam int CNT_W_DEF    = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_op_latency.sv
// alu_op_latency: combinational opcode -> latency lookup.
// Ports:
//   op_i       [3:0]        ALU opcode
//   lat_o      [CNT_W-1:0]  edges from accept to result capture
//   illegal_o               opcode outside 0x0-0xA (latency reported as 1)
module alu_op_latency
    import alu_pkg::*;
#(
    parameter int LAT_REG  = LAT_REG_DEF,
    parameter int LAT_COMB = LAT_COMB_DEF,
    parameter int LAT_MUL  = LAT_MUL_DEF,
    parameter int LAT_DIV  = LAT_DIV_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic [3:0]       op_i,
    output logic [CNT_W-1:0] lat_o,
    output logic             illegal_o
);

    always_comb begin
        lat_o     = CNT_W'(1);
        illegal_o = 1'b0;
        if (op_i <= OP_SHL) begin
            lat_o = CNT_W'(LAT_REG);
        end else if (op_i <= OP_SUB) begin
            lat_o = CNT_W'(LAT_COMB);
        end else if (op_i == OP_MUL) begin
            lat_o = CNT_W'(LAT_MUL);
        end else if (op_i <= OP_MAX) begin
            lat_o = CNT_W'(LAT_DIV);
        end else begin
            illegal_o = 1'b1;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: issues one ALU command at a time and returns its result.
// Ports:
//   clk, rst                   clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready        command handshake; cmd_op/cmd_a/cmd_b payload
//   alu_a/alu_b/alu_sel        ALU inputs, held from accept through response
//   alu_result                 ALU output, captured after the opcode latency
//   rsp_valid/rsp_ready        response handshake; rsp_result/zero/err payload
//   dbg_state                  current FSM state (IDLE/WAIT/DONE encoding)
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. valid holds with its payload stable until that edge; ready may
// be low at any time. cmd_valid seen while cmd_ready is low is ignored.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int LAT_REG  = LAT_REG_DEF,
    parameter int LAT_COMB = LAT_COMB_DEF,
    parameter int LAT_MUL  = LAT_MUL_DEF,
    parameter int LAT_DIV  = LAT_DIV_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_sel,
    input  logic [15:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_err,
    output logic [1:0]  dbg_state
);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [15:0]      rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_err_q, rsp_err_d;
    logic [15:0]      alu_a_q, alu_a_d;
    logic [15:0]      alu_b_q, alu_b_d;
    logic [3:0]       alu_sel_q, alu_sel_d;

    logic [CNT_W-1:0] op_lat;
    logic             op_illegal;

    alu_op_latency #(
        .LAT_REG  (LAT_REG),
        .LAT_COMB (LAT_COMB),
        .LAT_MUL  (LAT_MUL),
        .LAT_DIV  (LAT_DIV),
        .CNT_W    (CNT_W)
    ) u_lat (
        .op_i      (cmd_op),
        .lat_o     (op_lat),
        .illegal_o (op_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cmd_ready_d  = cmd_ready_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        unique case (state_q)
            IDLE: begin
                // Ready rises one edge after reset release and is dropped on accept.
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    alu_a_d     = cmd_a;
                    alu_b_d     = cmd_b;
                    alu_sel_d   = cmd_op;
                    cnt_d       = op_lat - CNT_W'(1);
                    cmd_ready_d = 1'b0;
                    if (op_illegal) begin
                        // Error payload is settled now; rsp_valid follows one edge
                        // later so the error path has the same timing as lat=1.
                        rsp_result_d = '0;
                        rsp_zero_d   = 1'b1;
                        rsp_err_d    = 1'b1;
                        state_d      = DONE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rsp_result_d = alu_result;
                    rsp_zero_d   = (alu_result == 16'h0000);
                    rsp_err_d    = 1'b0;
                    rsp_valid_d  = 1'b1;
                    state_d      = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                // DONE with rsp_valid low only occurs on the illegal-op path.
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_err    = rsp_err_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign dbg_state  = state_q;

endmodule
